// File: rtl/count_sequencer_pkg.sv
// Shared defaults, FSM state type and packed-table helper for the step sequencer.
package count_seq_pkg;

  localparam int DEF_NUM_STEPS  = 4;
  localparam int DEF_STEP_W     = 4;
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_START_STEP = 2;
  localparam int DEF_RESET_DATA = 1;
  localparam logic [15:0] DEF_TABLE_INIT = 16'h07C5;

  // Widest packed init vector / entry the helper handles (16 steps x 16 bits).
  localparam int INIT_MAX_W  = 256;
  localparam int ENTRY_MAX_W = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  function automatic logic [ENTRY_MAX_W-1:0] init_entry(
    input logic [INIT_MAX_W-1:0] init,
    input int                    k,
    input int                    w
  );
    logic [INIT_MAX_W-1:0] sh;
    logic [INIT_MAX_W-1:0] mask;
    sh   = init >> (k * w);
    mask = (INIT_MAX_W'(1) << w) - INIT_MAX_W'(1);
    return ENTRY_MAX_W'(sh & mask);
  endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Control, table-write and status signals of the step sequencer.
interface count_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              en;
  logic              start;
  logic              oneshot;
  logic              wr_en;
  logic [STEP_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STEP_W-1:0] step;
  logic [DATA_W-1:0] data;
  logic              running;
  logic              wrap;

  modport master (
    output en, start, oneshot, wr_en, wr_addr, wr_data,
    input  step, data, running, wrap
  );

  modport slave (
    input  en, start, oneshot, wr_en, wr_addr, wr_data,
    output step, data, running, wrap
  );
endinterface

// File: rtl/count_sequencer_table.sv
// NUM_STEPS x DATA_W register file: range-checked synchronous write, async read.
module seq_table
  import count_seq_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter logic [NUM_STEPS*DATA_W-1:0] TABLE_INIT = DEF_TABLE_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STEP_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_STEPS];

  // Addresses at or beyond NUM_STEPS match no entry, so such writes drop out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STEPS; k++)
        mem[k] <= DATA_W'(init_entry(INIT_MAX_W'(TABLE_INIT), k, DATA_W));
    end else begin
      for (int k = 0; k < NUM_STEPS; k++)
        if (wr_en && wr_addr == STEP_W'(k)) mem[k] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_STEPS; k++)
      if (rd_addr == STEP_W'(k)) rd_data = mem[k];
  end

endmodule

// File: rtl/count_sequencer.sv
// Programmable step sequencer: step counter, run/halt control, wrap pulse, data register.
//   state   | meaning
//   ST_RUN  | advances one step per cycle with en
//   ST_HALT | one-shot finished; holds until start or rst
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int NUM_STEPS  = DEF_NUM_STEPS,
  parameter int STEP_W     = DEF_STEP_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int START_STEP = DEF_START_STEP,
  parameter int RESET_DATA = DEF_RESET_DATA,
  parameter logic [NUM_STEPS*DATA_W-1:0] TABLE_INIT = DEF_TABLE_INIT
) (
  input  logic clk,
  input  logic rst,
  count_sequencer_if.slave bus
);

  seq_state_e        state, state_nxt;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              wrap_q, wrap_nxt;
  logic [DATA_W-1:0] rd_data;
  logic              last;

  seq_table #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W),
    .DATA_W    (DATA_W),
    .TABLE_INIT(TABLE_INIT)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_addr(step_q),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      step_q <= STEP_W'(START_STEP);
      data_q <= DATA_W'(RESET_DATA);
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= step_nxt;
      data_q <= data_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // rd_data is the pre-edge table contents, so a same-edge write is not seen.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_q;
    data_nxt  = data_q;
    wrap_nxt  = 1'b0;
    last      = (step_q == STEP_W'(NUM_STEPS - 1));
    if (bus.start) begin
      state_nxt = ST_RUN;
      step_nxt  = STEP_W'(START_STEP);
    end else if (state == ST_RUN && bus.en) begin
      data_nxt = rd_data;
      step_nxt = last ? '0 : step_q + STEP_W'(1);
      if (last) begin
        wrap_nxt = 1'b1;
        if (bus.oneshot) state_nxt = ST_HALT;
      end
    end
  end

  assign bus.step    = step_q;
  assign bus.data    = data_q;
  assign bus.running = (state == ST_RUN);
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_count_sequencer;

  localparam int NS    = 4;
  localparam int SW    = 4;
  localparam int DW    = 4;
  localparam int START = 2;
  localparam int RDATA = 1;
  localparam logic [15:0] TINIT = 16'h07C5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_sequencer_if #(.STEP_W(SW), .DATA_W(DW)) bus ();

  count_sequencer #(
    .NUM_STEPS(NS), .STEP_W(SW), .DATA_W(DW),
    .START_STEP(START), .RESET_DATA(RDATA), .TABLE_INIT(TINIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // behavioural model
  int m_step, m_data, m_run, m_wrap;
  int m_tab [NS];

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    n_cmp++;
    if (act !== 32'(expv)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    int rd;
    if (rst) begin
      m_step = START;
      m_data = RDATA;
      m_run  = 1;
      m_wrap = 0;
      for (int k = 0; k < NS; k++) m_tab[k] = int'((TINIT >> (k * DW)) & 16'hF);
    end else begin
      rd     = m_tab[m_step];
      m_wrap = 0;
      if (bus.start) begin
        m_step = START;
        m_run  = 1;
      end else if (m_run == 1 && bus.en) begin
        m_data = rd;
        if (m_step == NS - 1) begin
          m_wrap = 1;
          if (bus.oneshot) m_run = 0;
        end
        m_step = (m_step + 1) % NS;
      end
      if (bus.wr_en && int'(bus.wr_addr) < NS) m_tab[int'(bus.wr_addr)] = int'(bus.wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("step",    32'(bus.step),    m_step);
      chk("data",    32'(bus.data),    m_data);
      chk("running", 32'(bus.running), m_run);
      chk("wrap",    32'(bus.wrap),    m_wrap);
    end
  end

  task automatic cyc(input bit r, input bit e, input bit s, input bit os,
                     input bit we, input int wa, input int wd);
    rst         = r;
    bus.en      = e;
    bus.start   = s;
    bus.oneshot = os;
    bus.wr_en   = we;
    bus.wr_addr = SW'(wa);
    bus.wr_data = DW'(wd);
    @(negedge clk);
  endtask

  int exp_s [7] = '{2, 3, 0, 1, 2, 3, 0};
  int exp_d [7] = '{1, 7, 0, 5, 12, 7, 0};
  int exp_w [7] = '{0, 0, 1, 0, 0, 0, 1};
  int pass_d [4] = '{7, 0, 5, 12};

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // reset values and free-running pass
    chk("rst_step", 32'(bus.step), exp_s[0]);
    chk("rst_data", 32'(bus.data), exp_d[0]);
    chk("rst_running", 32'(bus.running), 1);
    chk("rst_wrap", 32'(bus.wrap), exp_w[0]);
    for (int i = 1; i < 7; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("free_step", 32'(bus.step), exp_s[i]);
      chk("free_data", 32'(bus.data), exp_d[i]);
      chk("free_wrap", 32'(bus.wrap), exp_w[i]);
    end

    // one-shot from step 0: 1,2,3,0 then halt
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0, 0, 0);
    chk("os_wrap", 32'(bus.wrap), 1);
    chk("os_running", 32'(bus.running), 0);
    chk("os_step", 32'(bus.step), 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("halt_step", 32'(bus.step), 0);
    chk("halt_data", 32'(bus.data), 0);
    chk("halt_wrap", 32'(bus.wrap), 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("resume_step", 32'(bus.step), 2);
    chk("resume_running", 32'(bus.running), 1);

    // start beats en at step 0
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("pre_start_step", 32'(bus.step), 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("start_en_step", 32'(bus.step), 2);
    chk("start_en_data", 32'(bus.data), 0);

    // write entry 3 on the edge that departs step 3
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 3, 9);
    chk("wr_same_edge_data", 32'(bus.data), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    chk("wr_next_pass_data", 32'(bus.data), 9);

    // reset mid-sequence with start, en and a write all pending
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0, 3);
    chk("midrst_step", 32'(bus.step), 2);
    chk("midrst_data", 32'(bus.data), 1);
    chk("midrst_running", 32'(bus.running), 1);
    chk("midrst_wrap", 32'(bus.wrap), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("midrst_table", 32'(bus.data), pass_d[i]);
    end

    // out-of-range write is dropped
    cyc(0, 0, 0, 0, 1, 5, 15);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("oob_table", 32'(bus.data), pass_d[i]);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 1,
          $urandom_range(0, 99) < 75,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 20,
          int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Parametrised step sequencer. A step counter walks through `NUM_STEPS` positions. On each advance it emits the value stored for the departing step from a run-time programmable table. It supersedes the fixed four-step status counter: step count, data width, start step, table contents and free-run/one-shot mode are all configurable, and it adds enable, restart and wrap signalling. It sits in the counter/timing experiments as a pattern generator driving downstream indexed logic.

## Interface
Parameters:
- `NUM_STEPS`, 4: number of sequence positions (2..16).
- `STEP_W`, 4: width of step index; must satisfy 2**STEP_W >= NUM_STEPS.
- `DATA_W`, 4: width of table entries and `data` output.
- `START_STEP`, 2: step loaded on reset and on `start`; must be < NUM_STEPS.
- `RESET_DATA`, 1: value of `data` after reset.
- `TABLE_INIT`, 16'h07C5: packed reset contents, entry k in bits [k*DATA_W +: DATA_W] (default gives 5, 12, 7, 0).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: advance one step this cycle while running.
- `start` in 1: reload `START_STEP` and set running.
- `oneshot` in 1: 1 = halt after the last step, 0 = wrap forever.
- `wr_en` in 1: table write strobe.
- `wr_addr` in STEP_W: table entry to write.
- `wr_data` in DATA_W: value to write.
- `step` out STEP_W: current step index.
- `data` out DATA_W: registered table value of last departed step.
- `running` out 1: sequencer will advance on `en`.
- `wrap` out 1: one-cycle pulse, step went NUM_STEPS-1 -> 0.

## Operation
- Reset (`rst`=1 at edge) sets the following. The table is reloaded too:
  - `step` = START_STEP
  - `data` = RESET_DATA
  - `running` = 1
  - `wrap` = 0
  - table = TABLE_INIT
- Advance condition: `running && en && !start`. On advance:
  - `data` <= table[step].
  - `step` <= (step == NUM_STEPS-1) ? 0 : step+1.
- Last-step advance:
  - `wrap` pulses 1 for the following cycle.
  - If `oneshot`=1 at that edge, `running` <= 0.
- Halted (`running`=0): `step` and `data` hold, `en` is ignored. Only `start` or `rst` resumes.
- `start`:
  - `step` <= START_STEP, `running` <= 1, `wrap` <= 0, `data` held.
  - Has priority over `en`.
  - Does not alter table contents.
- `oneshot` is sampled only on the last-step advance; changing it mid-sequence is legal.
- Table write on `wr_en`, independent of running state.
  - `wr_addr` >= NUM_STEPS: write ignored.
  - Write to the entry read on the same edge: `data` takes the old value. The new value is visible from the next cycle.
- Priority order: `rst` > `start` > advance > hold.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Advance latency: `step` and `data` update on the same edge that samples `en`=1.
- Table write-to-read latency: 1 cycle.
- `wrap` is high exactly one cycle per last-step advance, including the halting advance in one-shot.
- Continuous `en`: `step` period = NUM_STEPS cycles, and `wrap` period = NUM_STEPS cycles.
- Reset mid-sequence takes effect at the next edge, overriding any simultaneous `start`, `en` or `wr_en`.

## Structure
- Package `count_seq_pkg` contains:
  - default table constant (16'h07C5)
  - default parameter values
  - a function that extracts entry k from a packed init vector
- Sub-module `seq_table`, an NUM_STEPS x DATA_W register file:
  - synchronous write with range check
  - asynchronous read
  - synchronous reset to TABLE_INIT
- Top level holds the step counter, `running`/`wrap` control and the `data` output register.

## Test plan
- Reset with defaults, `en`=1 for 6 cycles:
  - `step` 2,3,0,1,2,3,0.
  - `data` 1,7,0,5,12,7,0.
  - `wrap` high the cycle after step 3 -> 0.
- `oneshot`=1, `en`=1 continuously:
  - `step` 2,3,0 then holds 0, `running` falls with `wrap` pulse.
  - Further `en` has no effect.
  - `start` resumes from step 2.
- `start`=1 and `en`=1 together at step 0 -> `step`=2 next cycle, `data` unchanged.
- Write 4'h9 to entry 3 on the same edge as advancing from step 3:
  - `data` gets 0.
  - Next pass through step 3 yields 9.
- `wr_addr`=5 with NUM_STEPS=4 -> no table change (full sequence 5,12,7,0 intact).
- `rst` asserted mid-sequence with a table write pending -> all outputs return to reset values and the table returns to TABLE_INIT.
